// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared defaults and types for the fetch address generator.
//   PC_XLEN_DEF   default PC width
//   RESET_VEC_DEF default reset fetch address
//   PC_INC        sequential fetch increment (bytes)
//   btb_entry_t   one BTB line {valid, tag, target}. Tag and target are held at
//                 the default PC width; narrower configurations zero-extend into them.
package pc_gen_pkg;

  localparam int          PC_XLEN_DEF   = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam int          PC_INC        = 4;

  typedef struct packed {
    logic                   valid;
    logic [PC_XLEN_DEF-1:0] tag;
    logic [PC_XLEN_DEF-1:0] target;
  } btb_entry_t;

endpackage

// File: rtl/pc_gen_unit_btb.sv
// pc_btb: direct-mapped branch target buffer.
//   i_clk, i_rst        clock / async active-high reset (clears every line)
//   i_lookup_pc         fetch PC, looked up combinationally
//   o_hit, o_target     lookup result (pre-update contents on a same-cycle write)
//   i_upd_*             resolved-branch update from execute, applied at posedge
// Index = pc[IDX+1:2], tag = pc[XLEN-1:IDX+2].
module pc_btb
  import pc_gen_pkg::*;
#(
  parameter int XLEN      = PC_XLEN_DEF,
  parameter int BTB_DEPTH = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_lookup_pc,
  output logic            o_hit,
  output logic [XLEN-1:0] o_target,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic            i_upd_taken
);

  localparam int IDX = $clog2(BTB_DEPTH);

  btb_entry_t tbl [BTB_DEPTH];

  logic [IDX-1:0]         lk_idx, up_idx;
  logic [PC_XLEN_DEF-1:0] lk_tag, up_tag;

  // Shifts rather than part-selects so every PC bit feeds the tag/index math.
  assign lk_idx = IDX'(i_lookup_pc >> 2);
  assign up_idx = IDX'(i_upd_pc >> 2);
  assign lk_tag = PC_XLEN_DEF'(i_lookup_pc >> (IDX + 2));
  assign up_tag = PC_XLEN_DEF'(i_upd_pc >> (IDX + 2));

  assign o_hit    = tbl[lk_idx].valid && (tbl[lk_idx].tag == lk_tag);
  assign o_target = XLEN'(tbl[lk_idx].target);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) tbl[i] <= '0;
    end else if (i_upd_valid) begin
      if (i_upd_taken) begin
        tbl[up_idx].valid  <= 1'b1;
        tbl[up_idx].tag    <= up_tag;
        tbl[up_idx].target <= PC_XLEN_DEF'(i_upd_target);
      end else if (tbl[up_idx].tag == up_tag) begin
        // Not-taken only evicts our own line; an alias is left alone.
        tbl[up_idx].valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: fetch PC register with stall hold, trap/redirect steering and
// optional BTB next-PC prediction.
//   i_clk, i_rst                    clock / async active-high reset
//   i_stall                         hold PC and flags
//   i_trap_valid, i_trap_vec        highest-priority redirect
//   i_redir_valid, i_redir_pc       execute mispredict redirect
//   i_upd_valid/pc/target/taken     BTB training from execute
//   o_pc, o_pc_valid                fetch address and its validity
//   o_pred_taken                    o_pc came from a BTB hit
//   o_misalign                      o_pc came from a target with nonzero [1:0]
// Build option: define PC_GEN_BTB_EN to include the BTB; otherwise prediction
// is absent and the update port is ignored.
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int              XLEN      = PC_XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEF,
  parameter int              BTB_DEPTH = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_vec,
  input  logic            i_redir_valid,
  input  logic [XLEN-1:0] i_redir_pc,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic            i_upd_taken,
  output logic [XLEN-1:0] o_pc,
  output logic            o_pc_valid,
  output logic            o_pred_taken,
  output logic            o_misalign
);

  logic [XLEN-1:0] pc_q, pc_n;
  logic            vld_q, pred_q, pred_n, mis_q, mis_n;
  logic            btb_hit;
  logic [XLEN-1:0] btb_target;

`ifdef PC_GEN_BTB_EN
  pc_btb #(.XLEN(XLEN), .BTB_DEPTH(BTB_DEPTH)) u_btb (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_lookup_pc  (pc_q),
    .o_hit        (btb_hit),
    .o_target     (btb_target),
    .i_upd_valid  (i_upd_valid),
    .i_upd_pc     (i_upd_pc),
    .i_upd_target (i_upd_target),
    .i_upd_taken  (i_upd_taken)
  );
`else
  logic unused_upd;
  assign unused_upd = ^{i_upd_valid, i_upd_pc, i_upd_target, i_upd_taken};
  assign btb_hit    = 1'b0;
  assign btb_target = '0;
`endif

  // Priority: trap > redirect > stall > BTB hit > sequential.
  always_comb begin
    pc_n   = pc_q + XLEN'(PC_INC);
    pred_n = 1'b0;
    mis_n  = 1'b0;
    if (i_trap_valid) begin
      pc_n  = {i_trap_vec[XLEN-1:2], 2'b00};
      mis_n = |i_trap_vec[1:0];
    end else if (i_redir_valid) begin
      pc_n  = {i_redir_pc[XLEN-1:2], 2'b00};
      mis_n = |i_redir_pc[1:0];
    end else if (i_stall) begin
      pc_n   = pc_q;
      pred_n = pred_q;
      mis_n  = mis_q;
    end else if (btb_hit) begin
      pc_n   = btb_target;
      pred_n = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q   <= RESET_VEC;
      vld_q  <= 1'b0;
      pred_q <= 1'b0;
      mis_q  <= 1'b0;
    end else if (!vld_q) begin
      // First edge out of reset only validates RESET_VEC; no advance yet.
      vld_q <= 1'b1;
    end else begin
      pc_q   <= pc_n;
      pred_q <= pred_n;
      mis_q  <= mis_n;
    end
  end

  assign o_pc         = pc_q;
  assign o_pc_valid   = vld_q;
  assign o_pred_taken = pred_q;
  assign o_misalign   = mis_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_stall = 1'b0;
  logic        i_trap_valid = 1'b0;
  logic [31:0] i_trap_vec = '0;
  logic        i_redir_valid = 1'b0;
  logic [31:0] i_redir_pc = '0;
  logic        i_upd_valid = 1'b0;
  logic [31:0] i_upd_pc = '0;
  logic [31:0] i_upd_target = '0;
  logic        i_upd_taken = 1'b0;
  logic [31:0] o_pc;
  logic        o_pc_valid, o_pred_taken, o_misalign;

  int n_chk = 0;
  int n_pass = 0;

  pc_gen_unit #(.XLEN(32), .RESET_VEC(32'h0), .BTB_DEPTH(16)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_stall       (i_stall),
    .i_trap_valid  (i_trap_valid),
    .i_trap_vec    (i_trap_vec),
    .i_redir_valid (i_redir_valid),
    .i_redir_pc    (i_redir_pc),
    .i_upd_valid   (i_upd_valid),
    .i_upd_pc      (i_upd_pc),
    .i_upd_target  (i_upd_target),
    .i_upd_taken   (i_upd_taken),
    .o_pc          (o_pc),
    .o_pc_valid    (o_pc_valid),
    .o_pred_taken  (o_pred_taken),
    .o_misalign    (o_misalign)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance one edge and sample 1ns later.
  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic expect_pc(input string tag, input logic [31:0] pc,
                           input logic pred, input logic mis);
    check({tag, ".pc"}, o_pc, pc);
    check({tag, ".pred"}, {31'b0, o_pred_taken}, {31'b0, pred});
    check({tag, ".mis"}, {31'b0, o_misalign}, {31'b0, mis});
  endtask

  task automatic redirect(input logic [31:0] tgt);
    i_redir_valid = 1'b1; i_redir_pc = tgt;
    step;
    i_redir_valid = 1'b0;
  endtask

  task automatic btb_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    i_upd_valid = 1'b1; i_upd_pc = pc; i_upd_target = tgt; i_upd_taken = tk;
    step;
    i_upd_valid = 1'b0;
  endtask

  initial begin
    // 1: reset state and release
    step; step;
    expect_pc("rst", 32'h0, 1'b0, 1'b0);
    check("rst.valid", {31'b0, o_pc_valid}, 32'd0);
    i_rst = 1'b0;
    step; expect_pc("rel0", 32'h0, 1'b0, 1'b0);
    check("rel0.valid", {31'b0, o_pc_valid}, 32'd1);
    step; expect_pc("seq4", 32'h4, 1'b0, 1'b0);
    step; expect_pc("seq8", 32'h8, 1'b0, 1'b0);
    step; step; check("seq10", o_pc, 32'h10);

    // 2: stall hold, redirect overrides stall
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step; check("stall", o_pc, 32'h10);
    end
    redirect(32'h200); check("stall_redir", o_pc, 32'h200);
    i_stall = 1'b0;

    // 3: trap beats redirect; misaligned redirect
    i_trap_valid = 1'b1; i_trap_vec = 32'h80;
    i_redir_valid = 1'b1; i_redir_pc = 32'h300;
    step; i_trap_valid = 1'b0; i_redir_valid = 1'b0;
    expect_pc("trap_win", 32'h80, 1'b0, 1'b0);
    redirect(32'h103); expect_pc("mis", 32'h100, 1'b0, 1'b1);
    step; expect_pc("mis_clr", 32'h104, 1'b0, 1'b0);
    // misaligned trap, held through a stall
    i_trap_valid = 1'b1; i_trap_vec = 32'h502; i_stall = 1'b1;
    step; i_trap_valid = 1'b0;
    expect_pc("trap_mis", 32'h500, 1'b0, 1'b1);
    step; expect_pc("mis_hold", 32'h500, 1'b0, 1'b1);
    i_stall = 1'b0;
    step; expect_pc("mis_adv", 32'h504, 1'b0, 1'b0);

`ifdef PC_GEN_BTB_EN
    // 4: BTB hit, then not-taken eviction
    btb_upd(32'h40, 32'h400, 1'b1);
    redirect(32'h3C); check("to3c", o_pc, 32'h3C);
    step; expect_pc("at40", 32'h40, 1'b0, 1'b0);
    step; expect_pc("hit", 32'h400, 1'b1, 1'b0);
    step; expect_pc("after_hit", 32'h404, 1'b0, 1'b0);
    btb_upd(32'h40, 32'h0, 1'b0);
    redirect(32'h40);
    step; expect_pc("evicted", 32'h44, 1'b0, 1'b0);
    // 5: alias shares index 0 but different tag
    btb_upd(32'h40, 32'h400, 1'b1);
    redirect(32'h80);
    step; expect_pc("alias", 32'h84, 1'b0, 1'b0);
    // not-taken at the alias must not evict 0x40
    btb_upd(32'h80, 32'h0, 1'b0);
    redirect(32'h40);
    step; expect_pc("alias_keep", 32'h400, 1'b1, 1'b0);
    // stall holds pred flag
    i_stall = 1'b1;
    redirect(32'h40);
    step; expect_pc("stall_no_hit", 32'h40, 1'b0, 1'b0);
    i_stall = 1'b0;
    step; expect_pc("hit2", 32'h400, 1'b1, 1'b0);
    i_stall = 1'b1;
    step; expect_pc("pred_hold", 32'h400, 1'b1, 1'b0);
    i_stall = 1'b0;
`else
    // No BTB: updates are ignored
    btb_upd(32'h40, 32'h400, 1'b1);
    redirect(32'h40);
    step; expect_pc("nobtb", 32'h44, 1'b0, 1'b0);
`endif

    // 6: wrap-around
    redirect(32'hFFFF_FFFC); check("top", o_pc, 32'hFFFF_FFFC);
    step; check("wrap", o_pc, 32'h0);
    step; check("wrap4", o_pc, 32'h4);

    // mid-run async reset takes effect immediately
    step;
    i_rst = 1'b1;
    #1;
    check("async_rst.pc", o_pc, 32'h0);
    check("async_rst.valid", {31'b0, o_pc_valid}, 32'd0);
    step;
    i_rst = 1'b0;
    step; check("rerel.valid", {31'b0, o_pc_valid}, 32'd1);
    check("rerel.pc", o_pc, 32'h0);
    redirect(32'h40);
    step; expect_pc("btb_empty", 32'h44, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
